data_mem_responder: RTL and testbench

Data-memory responder for the single-cycle core's load/store path. It answers the ALU-side memory requests (`read`, `write`, `addr`, `write_data_mem`), holds the data RAM, applies byte, half and word lane steering on stores, and applies sign or zero extension on loads. It returns read data on `mem` with a one-cycle `ready` strobe. It sits between the ALU/LSU and the on-chip data RAM, and it stalls the core through `busy` during wait states.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_load_align.sv | 26 ++
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Byte-lane enables for a store of the given size at byte offset lane.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    byte_en = 4'b0001 << lane;
      SZ_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path: pick the addressed byte/half out of a RAM word and extend it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  output logic [31:0] out
);

  logic [15:0] shifted;

  // Shift the addressed lane down to bit 0, then sign or zero extend.
  always_comb begin
    shifted = 16'(word >> {lane, 3'b000});
    out     = '0;
    case (size)
      SZ_B:    out = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
      SZ_H:    out = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
      SZ_W:    out = word;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: request FSM with programmable wait states,
// byte-enabled data RAM and extended load data with a one-cycle ready.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data_mem,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] mem,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t              state, state_next;
  logic [2:0]          cnt;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          size_q;
  logic                uns_q, is_write_q, reject_q;

  logic [31:0]         ram [DEPTH];
  logic [31:0]         rdata;

  logic                accept, reject_now, enter_resp;
  logic [ADDR_W+1:0]   a_addr;
  logic [31:0]         a_wdata;
  logic [1:0]          a_size;
  logic                a_write, a_reject;
  logic [ADDR_W-1:0]   widx;
  logic [3:0]          be;
  logic [31:0]         wlanes;
  logic [31:0]         load_ext;

  assign accept = (state == IDLE) && (read || write);

  // A request is rejected for conflicting ops, bad size, misalignment or out-of-range address.
  always_comb begin
    reject_now = (read && write)
              || (size == 2'b11)
              || ((size == SZ_H) && addr[0])
              || ((size == SZ_W) && (addr[1:0] != 2'b00))
              || ((addr >> (ADDR_W + 2)) != 32'd0);
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (read || write) begin
          if (WAIT_CYCLES > 0) state_next = WAIT;
          else                 state_next = RESP;
        end
      end
      WAIT:    if (cnt == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Request latches and wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      is_write_q <= 1'b0;
      reject_q   <= 1'b0;
    end else if (accept) begin
      cnt        <= CNT_LOAD;
      addr_q     <= addr[ADDR_W+1:0];
      wdata_q    <= write_data_mem;
      size_q     <= size;
      uns_q      <= unsigned_ld;
      is_write_q <= write;
      reject_q   <= reject_now;
    end else if ((state == WAIT) && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  // With no wait states the RAM is accessed on the acceptance edge itself,
  // before the latches are loaded, so the live (held) inputs are used in IDLE.
  assign a_addr   = (state == IDLE) ? addr[ADDR_W+1:0] : addr_q;
  assign a_wdata  = (state == IDLE) ? write_data_mem   : wdata_q;
  assign a_size   = (state == IDLE) ? size             : size_q;
  assign a_write  = (state == IDLE) ? write            : is_write_q;
  assign a_reject = (state == IDLE) ? reject_now       : reject_q;

  assign widx       = a_addr[ADDR_W+1:2];
  assign be         = a_reject ? 4'b0000 : byte_en(a_size, a_addr[1:0]);
  assign enter_resp = (state != RESP) && (state_next == RESP) && rst_n;

  // Replicate store data so every enabled lane sees its little-endian byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wlanes[gi*8 +: 8] = (a_size == SZ_B) ? a_wdata[7:0] :
                                 (a_size == SZ_H) ? a_wdata[(gi%2)*8 +: 8] :
                                                    a_wdata[gi*8 +: 8];
    end
  endgenerate

  // Data RAM: byte-enabled write and registered read on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      for (int i = 0; i < 4; i++) begin
        if (a_write && be[i]) ram[widx][i*8 +: 8] <= wlanes[i*8 +: 8];
      end
      rdata <= ram[widx];
    end
  end

  dmem_load_align u_align (
    .word        (rdata),
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .unsigned_ld (uns_q),
    .out         (load_ext)
  );

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = ready && reject_q;
  assign mem   = (ready && !reject_q && !is_write_q) ? load_ext : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized accesses against a byte-array reference model.
module tb_data_mem_responder;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read, write, unsigned_ld;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] mem;
  logic        ready, busy, err;

  logic        z_read, z_write, z_uns;
  logic [31:0] z_addr, z_wdata;
  logic [1:0]  z_size;
  logic [31:0] z_mem;
  logic        z_ready, z_busy, z_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [4096];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .write_data_mem(wdata), .size(size), .unsigned_ld(unsigned_ld),
    .mem(mem), .ready(ready), .busy(busy), .err(err)
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .read(z_read), .write(z_write), .addr(z_addr),
    .write_data_mem(z_wdata), .size(z_size), .unsigned_ld(z_uns),
    .mem(z_mem), .ready(z_ready), .busy(z_busy), .err(z_err)
  );

  // Reference: rejection rules for a 4 KiB byte space.
  function automatic bit m_err(bit rd, bit wr, logic [31:0] a, logic [1:0] sz);
    return (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0)
        || (sz == 2'b10 && (a % 4) != 0) || (a >= 32'd4096);
  endfunction

  // Reference: little-endian load with arithmetic sign handling.
  function automatic logic [31:0] m_load(logic [31:0] a, logic [1:0] sz, bit u);
    longint v;
    int b;
    b = int'(a[11:0]);
    case (sz)
      2'b00: begin
        v = longint'(mb[b]);
        if (!u && v >= 128) v -= 256;
      end
      2'b01: begin
        v = longint'(mb[b]) + 256 * longint'(mb[b+1]);
        if (!u && v >= 32768) v -= 65536;
      end
      default: v = longint'(mb[b]) + 256 * longint'(mb[b+1])
                 + 65536 * longint'(mb[b+2]) + 16777216 * longint'(mb[b+3]);
    endcase
    return v[31:0];
  endfunction

  function automatic void m_store(logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mb[int'(a[11:0]) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endfunction

  // Issue one request in an IDLE cycle, hold it until ready (bounded), then release.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit u,
                        output logic [31:0] m, output logic e, output int lat,
                        output logic b_idle, output logic b_wait);
    @(negedge clk);
    read = rd; write = wr; addr = a; wdata = wd; size = sz; unsigned_ld = u;
    b_idle = busy;
    b_wait = 1'b1;
    lat = -1; m = 'x; e = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      b_wait = b_wait & busy;
      if (ready) begin
        lat = k; m = mem; e = err;
        break;
      end
    end
    read = 1'b0; write = 1'b0;
    if (wr && !rd && !m_err(rd, wr, a, sz)) m_store(a, sz, wd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read = 0; write = 0; addr = 0; wdata = 0; size = 0; unsigned_ld = 0;
    z_read = 0; z_write = 0; z_addr = 0; z_wdata = 0; z_size = 0; z_uns = 0;
    repeat (3) @(negedge clk);
    total++; if (mem !== 32'd0) begin bad++; $display("FAIL reset_mem got=%h exp=0", mem); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    $display("reset: mem=%h ready=%b busy=%b err=%b", mem, ready, busy, err);
  endtask

  // Ready appears in the (W+1)th cycle after the IDLE acceptance cycle.
  task automatic test_word_roundtrip();
    logic [31:0] m; logic e, bi, bw; int lat;
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, m, e, lat, bi, bw);
    $display("sw @10: mem=%h err=%b lat=%0d", m, e, lat);
    total++; if (m !== 32'd0 || e !== 1'b0) begin bad++; $display("FAIL sw_resp got mem=%h err=%b exp mem=0 err=0", m, e); end
    total++; if (lat !== W + 1) begin bad++; $display("FAIL sw_latency got=%0d exp=%0d", lat, W + 1); end
    total++; if (bi !== 1'b0 || bw !== 1'b1) begin bad++; $display("FAIL sw_busy got idle=%b wait=%b exp idle=0 wait=1", bi, bw); end
    do_req(1, 0, 32'h10, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    $display("lw @10: mem=%h err=%b lat=%0d", m, e, lat);
    total++; if (m !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", m); end
    total++; if (e !== 1'b0 || lat !== W + 1) begin bad++; $display("FAIL lw_err_lat got err=%b lat=%0d exp err=0 lat=%0d", e, lat, W + 1); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] m; logic e, bi, bw; int lat;
    do_req(0, 1, 32'h20, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    do_req(0, 1, 32'h23, 32'h80, 2'b00, 0, m, e, lat, bi, bw);
    do_req(1, 0, 32'h20, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    $display("lw @20: mem=%h err=%b", m, e);
    total++; if (m !== 32'h80000000) begin bad++; $display("FAIL sb_lane3 got=%h exp=80000000", m); end
    do_req(1, 0, 32'h23, 32'h0, 2'b00, 0, m, e, lat, bi, bw);
    $display("lb @23: mem=%h err=%b", m, e);
    total++; if (m !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sext got=%h exp=ffffff80", m); end
    do_req(1, 0, 32'h23, 32'h0, 2'b00, 1, m, e, lat, bi, bw);
    $display("lbu @23: mem=%h err=%b", m, e);
    total++; if (m !== 32'h00000080) begin bad++; $display("FAIL lbu_zext got=%h exp=00000080", m); end
  endtask

  task automatic test_half();
    logic [31:0] m; logic e, bi, bw; int lat;
    do_req(0, 1, 32'h32, 32'h8001, 2'b01, 0, m, e, lat, bi, bw);
    do_req(1, 0, 32'h32, 32'h0, 2'b01, 0, m, e, lat, bi, bw);
    $display("lh @32: mem=%h err=%b", m, e);
    total++; if (m !== 32'hFFFF8001) begin bad++; $display("FAIL lh_sext got=%h exp=ffff8001", m); end
    do_req(1, 0, 32'h32, 32'h0, 2'b01, 1, m, e, lat, bi, bw);
    $display("lhu @32: mem=%h err=%b", m, e);
    total++; if (m !== 32'h00008001) begin bad++; $display("FAIL lhu_zext got=%h exp=00008001", m); end
    do_req(1, 0, 32'h30, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    $display("lw @30: mem=%h err=%b", m, e);
    total++; if (m[31:16] !== 16'h8001) begin bad++; $display("FAIL sh_upper got=%h exp=8001", m[31:16]); end
  endtask

  task automatic test_errors();
    logic [31:0] m; logic e, bi, bw; int lat;
    do_req(0, 1, 32'h0, 32'h13579BDF, 2'b10, 0, m, e, lat, bi, bw);
    do_req(1, 0, 32'h11, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    $display("lw @11: mem=%h err=%b lat=%0d", m, e, lat);
    total++; if (e !== 1'b1 || m !== 32'd0) begin bad++; $display("FAIL err_misalign got err=%b mem=%h exp err=1 mem=0", e, m); end
    total++; if (lat !== W + 1) begin bad++; $display("FAIL err_latency got=%0d exp=%0d", lat, W + 1); end
    do_req(1, 1, 32'h0, 32'hFFFFFFFF, 2'b10, 0, m, e, lat, bi, bw);
    $display("rd+wr @0: mem=%h err=%b", m, e);
    total++; if (e !== 1'b1 || m !== 32'd0) begin bad++; $display("FAIL err_rdwr got err=%b mem=%h exp err=1 mem=0", e, m); end
    do_req(1, 0, 32'h0, 32'h0, 2'b11, 0, m, e, lat, bi, bw);
    $display("size11 @0: mem=%h err=%b", m, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_size got=%b exp=1", e); end
    do_req(0, 1, 32'h1000, 32'h55555555, 2'b10, 0, m, e, lat, bi, bw);
    $display("sw @1000: mem=%h err=%b", m, e);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_range got=%b exp=1", e); end
    do_req(1, 0, 32'h0, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    $display("lw @0: mem=%h err=%b", m, e);
    total++; if (m !== 32'h13579BDF || e !== 1'b0) begin bad++; $display("FAIL err_no_write got=%h err=%b exp=13579bdf err=0", m, e); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] m; logic e, bi, bw; int lat; logic seen;
    do_req(0, 1, 32'h40, 32'hAAAAAAAA, 2'b10, 0, m, e, lat, bi, bw);
    @(negedge clk);
    read = 0; write = 1; addr = 32'h40; wdata = 32'h12345678; size = 2'b10; unsigned_ld = 0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_in_wait got busy=%b exp=1", busy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_async got ready=%b busy=%b exp 0 0", ready, busy); end
    write = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | ready;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_ready got=%b exp=0", seen); end
    rst_n = 1'b1;
    do_req(1, 0, 32'h40, 32'h0, 2'b10, 0, m, e, lat, bi, bw);
    $display("abort then lw @40: mem=%h err=%b", m, e);
    total++; if (m !== 32'hAAAAAAAA) begin bad++; $display("FAIL abort_dropped got=%h exp=aaaaaaaa", m); end
  endtask

  // Zero wait states: a held read is answered every second cycle.
  task automatic test_wait0();
    logic exp_r;
    @(negedge clk);
    z_write = 1; z_read = 0; z_addr = 32'h8; z_wdata = 32'hCAFEF00D; z_size = 2'b10; z_uns = 0;
    total++; if (z_busy !== 1'b0) begin bad++; $display("FAIL w0_busy_accept got=%b exp=0", z_busy); end
    @(negedge clk);
    total++; if (z_ready !== 1'b1 || z_err !== 1'b0) begin bad++; $display("FAIL w0_sw_resp got ready=%b err=%b exp 1 0", z_ready, z_err); end
    z_write = 0;
    z_read = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_r = (k % 2) == 1;
      $display("w0 cycle %0d: ready=%b busy=%b mem=%h", k, z_ready, z_busy, z_mem);
      total++; if (z_ready !== exp_r || z_busy !== exp_r) begin bad++; $display("FAIL w0_b2b_%0d got ready=%b busy=%b exp=%b", k, z_ready, z_busy, exp_r); end
      total++; if (z_mem !== (exp_r ? 32'hCAFEF00D : 32'd0)) begin bad++; $display("FAIL w0_mem_%0d got=%h exp=%h", k, z_mem, exp_r ? 32'hCAFEF00D : 32'd0); end
    end
    z_read = 0;
  endtask

  task automatic test_random();
    logic [31:0] m, a, wd, exp_m; logic e, bi, bw, exp_e; int lat, r; bit rd, wr, u; logic [1:0] sz;
    for (int i = 0; i < 64; i++) do_req(0, 1, 32'(i * 4), $urandom, 2'b10, 0, m, e, lat, bi, bw);
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
      exp_e = m_err(rd, wr, a, sz);
      exp_m = (exp_e || wr) ? 32'd0 : m_load(a, sz, u);
      do_req(rd, wr, a, wd, sz, u, m, e, lat, bi, bw);
      $display("rand %0d: rd=%b wr=%b a=%h sz=%0d u=%b wd=%h mem=%h err=%b lat=%0d", i, rd, wr, a, sz, u, wd, m, e, lat);
      total++; if (m !== exp_m || e !== exp_e) begin bad++; $display("FAIL rand_%0d got mem=%h err=%b exp mem=%h err=%b", i, m, e, exp_m, exp_e); end
      total++; if (lat !== W + 1 || bi !== 1'b0 || bw !== 1'b1) begin bad++; $display("FAIL rand_timing_%0d got lat=%0d busy_idle=%b busy_wait=%b exp lat=%0d 0 1", i, lat, bi, bw, W + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_byte_lanes();
    test_half();
    test_errors();
    test_reset_abort();
    test_wait0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
